// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } rx_state_e;

    // Smallest divisor that leaves room for three votes and a wrap per bit.
    localparam int UART_MIN_DIV = 8;

endpackage
`default_nettype wire

// File: rtl/uart_rx_framed_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_framed_if
//  Description : Holding-register handshake and status of the UART receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic                 o_valid;
    logic                 i_ready;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_parity_err;
    logic                 o_frame_err;
    logic                 o_overrun;
    logic                 o_break;

    // Receiver side: produces words, consumes ready.
    modport master (
        output o_valid, o_data, o_parity_err, o_frame_err, o_overrun, o_break,
        input  i_ready
    );

    // Consumer side.
    modport slave (
        input  o_valid, o_data, o_parity_err, o_frame_err, o_overrun, o_break,
        output i_ready
    );
endinterface
`default_nettype wire

// File: rtl/synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : synchronizer
//  Description : Two-flop synchroniser for an asynchronous single-bit input.
//  Revision    : 1.0 - initial release
// ============================================================================
module synchronizer #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic n_rst,
    input  wire logic i_d,
    output logic      o_q
);
    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; the first may go metastable, the second settles.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/uart_bit_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_sampler
//  Description : Per-bit sample counter with mid-bit 3-sample majority vote.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_sampler #(
    parameter int DIV_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic [DIV_W-1:0] i_div,
    input  wire logic             i_rx,
    output logic                  o_vote_stb,
    output logic                  o_vote,
    output logic                  o_wrap
);
    localparam logic [DIV_W-1:0] c_one = DIV_W'(1);

    logic [DIV_W-1:0] r_count;
    logic [DIV_W-1:0] w_mid;
    logic             r_s0;
    logic             r_s1;

    assign w_mid      = i_div >> 1;
    assign o_wrap     = (r_count == i_div - c_one);
    assign o_vote_stb = (r_count == w_mid + c_one);
    // Third sample is the live line, so the decision is ready at mid+1.
    assign o_vote     = (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);

    // Sample counter: held at zero while cleared, wraps at div-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear || o_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_one;
        end
    end

    // Capture the first two votes at mid-1 and mid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else begin
            if (r_count == w_mid - c_one) r_s0 <= i_rx;
            if (r_count == w_mid)         r_s1 <= i_rx;
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_rx_framed.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_framed
//  Description : Parametrised UART receiver with runtime divisor, parity,
//                framing/overrun/break detection and a valid/ready holder.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_rx,
    input  wire logic [DIV_W-1:0] i_clks_per_bit,
    uart_rx_framed_if.master      bus
);
    localparam int                 c_bit_w     = $clog2(DATA_BITS + 1);
    localparam logic [c_bit_w-1:0] c_data_bits = c_bit_w'(DATA_BITS);
    localparam logic [c_bit_w-1:0] c_last_stop = c_bit_w'(STOP_BITS - 1);
    localparam logic [c_bit_w-1:0] c_cnt_one   = c_bit_w'(1);
    localparam logic [DIV_W-1:0]   c_min_div   = DIV_W'(UART_MIN_DIV);
    localparam parity_e            c_parity    = (PARITY == 2) ? PARITY_EVEN :
                                                 (PARITY == 1) ? PARITY_ODD  :
                                                                 PARITY_NONE;

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $error("uart_rx_framed: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
        $error("uart_rx_framed: PARITY must be 0..2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
        $error("uart_rx_framed: STOP_BITS must be 1 or 2");
    end

    logic                 w_n_rst;
    logic                 w_rx_s;
    logic                 w_vote_stb, w_vote, w_wrap;
    logic [DIV_W-1:0]     w_div_in;
    logic                 w_par_exp;
    logic                 w_load;
    rx_state_e            r_state, w_next;
    logic [DIV_W-1:0]     r_div_q;
    logic [DATA_BITS-1:0] r_shift;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic                 r_par_bit, r_perr, r_ferr;
    logic                 w_clear, w_start, w_shift, w_par_chk, w_stop_chk;
    logic                 w_bit_clr, w_bit_inc, w_done, w_brk;

    assign w_n_rst = ~rst;

    synchronizer #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .n_rst (w_n_rst),
        .i_d   (i_rx),
        .o_q   (w_rx_s)
    );

    uart_bit_sampler #(.DIV_W(DIV_W)) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_div      (r_div_q),
        .i_rx       (w_rx_s),
        .o_vote_stb (w_vote_stb),
        .o_vote     (w_vote),
        .o_wrap     (w_wrap)
    );

    // Out-of-range divisors are raised to the minimum so the vote window fits.
    assign w_div_in  = (i_clks_per_bit < c_min_div) ? c_min_div : i_clks_per_bit;
    assign w_par_exp = (c_parity == PARITY_EVEN) ? ^r_shift : ~^r_shift;
    assign w_load    = w_done && (!bus.o_valid || bus.i_ready);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // FSM next state and per-state datapath strobes.
    always_comb begin
        w_next     = r_state;
        w_clear    = 1'b0;
        w_start    = 1'b0;
        w_shift    = 1'b0;
        w_par_chk  = 1'b0;
        w_stop_chk = 1'b0;
        w_bit_clr  = 1'b0;
        w_bit_inc  = 1'b0;
        w_done     = 1'b0;
        w_brk      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clear = 1'b1;
                if (!w_rx_s) begin
                    w_start = 1'b1;
                    w_next  = ST_START;
                end
            end
            ST_START: begin
                if (w_vote_stb && w_vote) w_next = ST_IDLE;
                else if (w_wrap)          w_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_vote_stb) w_shift = 1'b1;
                if (w_wrap && r_bit_cnt == c_data_bits) begin
                    w_bit_clr = 1'b1;
                    w_next    = (c_parity == PARITY_NONE) ? ST_STOP : ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (w_vote_stb) w_par_chk = 1'b1;
                if (w_wrap)     w_next    = ST_STOP;
            end
            ST_STOP: begin
                if (w_vote_stb) begin
                    w_stop_chk = 1'b1;
                    if (r_bit_cnt == '0 && r_shift == '0 && !r_par_bit && !w_vote) begin
                        w_brk  = 1'b1;
                        w_next = ST_BREAK_WAIT;
                    end else if (r_bit_cnt == c_last_stop) begin
                        // Complete at the vote, not the bit end, to catch the next edge.
                        w_done = 1'b1;
                        w_next = ST_IDLE;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            ST_BREAK_WAIT: begin
                w_clear = 1'b1;
                if (w_rx_s) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Frame datapath: divisor latch, shift register, bit counter, error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_q   <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            if (w_start) begin
                r_div_q   <= w_div_in;
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_par_bit <= 1'b0;
                r_perr    <= 1'b0;
                r_ferr    <= 1'b0;
            end
            if (w_shift) begin
                r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + c_cnt_one;
            end
            if (w_bit_clr) r_bit_cnt <= '0;
            if (w_bit_inc) r_bit_cnt <= r_bit_cnt + c_cnt_one;
            if (w_par_chk) begin
                r_par_bit <= w_vote;
                r_perr    <= w_vote ^ w_par_exp;
            end
            if (w_stop_chk && !w_vote) r_ferr <= 1'b1;
        end
    end

    // Holding register with overrun and break pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.o_valid      <= 1'b0;
            bus.o_data       <= '0;
            bus.o_parity_err <= 1'b0;
            bus.o_frame_err  <= 1'b0;
            bus.o_overrun    <= 1'b0;
            bus.o_break      <= 1'b0;
        end else begin
            bus.o_overrun <= w_done && bus.o_valid && !bus.i_ready;
            bus.o_break   <= w_brk;
            if (w_load) begin
                bus.o_valid      <= 1'b1;
                bus.o_data       <= r_shift;
                bus.o_parity_err <= r_perr;
                // The last stop vote has not reached r_ferr yet.
                bus.o_frame_err  <= r_ferr | ~w_vote;
            end else if (bus.o_valid && bus.i_ready) begin
                bus.o_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framed.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_framed
//  Description : Directed self-checking bench for uart_rx_framed (8N1 and 8E1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_framed;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_n = 1'b1;
    logic        rx_p = 1'b1;
    logic [15:0] div_n = 16'd16;
    logic [15:0] div_p = 16'd16;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ovr_n = 0, brk_n = 0, ovr_p = 0, brk_p = 0;
    logic prev_v = 1'b0;
    logic [9:0] cap_n[$];
    logic [9:0] cap_p[$];
    int         rise_q[$];

    uart_rx_framed_if #(.DATA_BITS(8)) bus_n ();
    uart_rx_framed_if #(.DATA_BITS(8)) bus_p ();

    uart_rx_framed #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rx           (rx_n),
        .i_clks_per_bit (div_n),
        .bus            (bus_n)
    );

    uart_rx_framed #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_W(16)) dut_p (
        .clk            (clk),
        .rst            (rst),
        .i_rx           (rx_p),
        .i_clks_per_bit (div_p),
        .bus            (bus_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records accepted words, pulse cycles and o_valid rise times.
    always @(negedge clk) begin
        if (bus_n.o_valid && bus_n.i_ready)
            cap_n.push_back({bus_n.o_frame_err, bus_n.o_parity_err, bus_n.o_data});
        if (bus_p.o_valid && bus_p.i_ready)
            cap_p.push_back({bus_p.o_frame_err, bus_p.o_parity_err, bus_p.o_data});
        if (bus_n.o_overrun) ovr_n++;
        if (bus_n.o_break)   brk_n++;
        if (bus_p.o_overrun) ovr_p++;
        if (bus_p.o_break)   brk_p++;
        if (bus_n.o_valid && !prev_v) rise_q.push_back(cyc);
        prev_v = bus_n.o_valid;
    end

    function automatic logic [15:0] f8n1(input logic [7:0] d, input logic stop);
        return {6'b111111, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] f8e1(input logic [7:0] d, input logic par, input logic stop);
        return {5'b11111, stop, par, d, 1'b0};
    endfunction

    // Drive n bits LSB first, div clocks each; optionally retune dut mid-frame.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n,
                             input int div, input int chg_bit, input logic [15:0] chg_div);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rx_n = bits[i];
            else          rx_p = bits[i];
            if (i == chg_bit) div_n = chg_div;
            repeat (div) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int cycles);
        rx_n = 1'b1;
        rx_p = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({bus_n.o_valid, bus_n.o_parity_err, bus_n.o_frame_err, bus_n.o_overrun, bus_n.o_break} !== 5'b0)
            $display("FAIL reset_flags got %b want 00000",
                     {bus_n.o_valid, bus_n.o_parity_err, bus_n.o_frame_err, bus_n.o_overrun, bus_n.o_break});
        else n_pass++;
        n_checks++;
        if (bus_n.o_data !== 8'h00) $display("FAIL reset_data got %h want 00", bus_n.o_data);
        else n_pass++;
        n_checks++;
        if ({bus_p.o_valid, bus_p.o_data} !== 9'h0) $display("FAIL reset_par_dut got %h want 000", {bus_p.o_valid, bus_p.o_data});
        else n_pass++;
        rst = 1'b0;
        idle(10);
    endtask

    task automatic test_nominal;
        int edge_cyc;
        cap_n.delete();
        rise_q.delete();
        edge_cyc = cyc;
        send_bits(0, f8n1(8'h55, 1'b1), 10, 16, -1, 16'd0);
        send_bits(0, f8n1(8'hA3, 1'b1), 10, 16, -1, 16'd0);
        idle(40);
        n_checks++;
        if (cap_n.size() !== 2) $display("FAIL nominal_count got %0d want 2", cap_n.size());
        else n_pass++;
        n_checks++;
        if (cap_n[0] !== {2'b00, 8'h55}) $display("FAIL nominal_word0 got %h want 055", cap_n[0]);
        else n_pass++;
        n_checks++;
        if (cap_n[1] !== {2'b00, 8'hA3}) $display("FAIL nominal_word1 got %h want 0a3", cap_n[1]);
        else n_pass++;
        n_checks++;
        if (rise_q.size() < 1 || rise_q[0] - edge_cyc < 154 || rise_q[0] - edge_cyc > 160)
            $display("FAIL nominal_latency got %0d want 154..160",
                     (rise_q.size() > 0) ? rise_q[0] - edge_cyc : -1);
        else n_pass++;
        n_checks++;
        if (ovr_n !== 0 || brk_n !== 0) $display("FAIL nominal_pulses got ovr=%0d brk=%0d want 0 0", ovr_n, brk_n);
        else n_pass++;
    endtask

    task automatic test_parity;
        cap_p.delete();
        send_bits(1, f8e1(8'hA5, 1'b1, 1'b1), 11, 16, -1, 16'd0);
        send_bits(1, f8e1(8'hA5, 1'b0, 1'b1), 11, 16, -1, 16'd0);
        idle(40);
        n_checks++;
        if (cap_p.size() !== 2) $display("FAIL parity_count got %0d want 2", cap_p.size());
        else n_pass++;
        n_checks++;
        if (cap_p[0] !== {2'b01, 8'hA5}) $display("FAIL parity_bad got %h want 1a5", cap_p[0]);
        else n_pass++;
        n_checks++;
        if (cap_p[1] !== {2'b00, 8'hA5}) $display("FAIL parity_good got %h want 0a5", cap_p[1]);
        else n_pass++;
    endtask

    task automatic test_frame_err;
        int b0;
        b0 = brk_n;
        cap_n.delete();
        send_bits(0, f8n1(8'h3C, 1'b0), 10, 16, -1, 16'd0);
        idle(60);
        n_checks++;
        if (cap_n.size() !== 1) $display("FAIL frame_count got %0d want 1", cap_n.size());
        else n_pass++;
        n_checks++;
        if (cap_n[0] !== {2'b10, 8'h3C}) $display("FAIL frame_err got %h want 23c", cap_n[0]);
        else n_pass++;
        n_checks++;
        if (brk_n - b0 !== 0) $display("FAIL frame_no_break got %0d want 0", brk_n - b0);
        else n_pass++;
    endtask

    task automatic test_false_start;
        cap_n.delete();
        rx_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(40);
        n_checks++;
        if (cap_n.size() !== 0) $display("FAIL glitch_no_valid got %0d want 0", cap_n.size());
        else n_pass++;
        send_bits(0, f8n1(8'h5A, 1'b1), 10, 16, -1, 16'd0);
        idle(40);
        n_checks++;
        if (cap_n.size() !== 1) $display("FAIL glitch_next_count got %0d want 1", cap_n.size());
        else n_pass++;
        n_checks++;
        if (cap_n[0] !== {2'b00, 8'h5A}) $display("FAIL glitch_next_word got %h want 05a", cap_n[0]);
        else n_pass++;
    endtask

    task automatic test_overrun;
        int o0;
        o0 = ovr_n;
        bus_n.i_ready = 1'b0;
        cap_n.delete();
        send_bits(0, f8n1(8'h11, 1'b1), 10, 16, -1, 16'd0);
        send_bits(0, f8n1(8'h22, 1'b1), 10, 16, -1, 16'd0);
        idle(40);
        n_checks++;
        if (bus_n.o_valid !== 1'b1) $display("FAIL overrun_valid got %b want 1", bus_n.o_valid);
        else n_pass++;
        n_checks++;
        if (bus_n.o_data !== 8'h11) $display("FAIL overrun_data got %h want 11", bus_n.o_data);
        else n_pass++;
        n_checks++;
        if (ovr_n - o0 !== 1) $display("FAIL overrun_pulse got %0d want 1", ovr_n - o0);
        else n_pass++;
        bus_n.i_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus_n.o_valid !== 1'b0) $display("FAIL overrun_drop got %b want 0", bus_n.o_valid);
        else n_pass++;
        n_checks++;
        if (cap_n.size() !== 1 || cap_n[0] !== {2'b00, 8'h11})
            $display("FAIL overrun_accept got n=%0d w=%h want n=1 w=011", cap_n.size(), cap_n[0]);
        else n_pass++;
    endtask

    task automatic test_break;
        int b0;
        b0 = brk_n;
        cap_n.delete();
        rx_n = 1'b0;
        repeat (12 * 16) @(posedge clk);
        #1;
        idle(40);
        n_checks++;
        if (brk_n - b0 !== 1) $display("FAIL break_pulse got %0d want 1", brk_n - b0);
        else n_pass++;
        n_checks++;
        if (cap_n.size() !== 0) $display("FAIL break_no_valid got %0d want 0", cap_n.size());
        else n_pass++;
        send_bits(0, f8n1(8'h7E, 1'b1), 10, 16, -1, 16'd0);
        idle(40);
        n_checks++;
        if (cap_n.size() !== 1 || cap_n[0] !== {2'b00, 8'h7E})
            $display("FAIL break_next got n=%0d w=%h want n=1 w=07e", cap_n.size(), cap_n[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        bus_n.i_ready = 1'b0;
        send_bits(0, f8n1(8'h33, 1'b1), 10, 16, -1, 16'd0);
        idle(30);
        send_bits(0, f8n1(8'hC3, 1'b1), 4, 16, -1, 16'd0);
        rst  = 1'b1;
        rx_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus_n.o_valid, bus_n.o_parity_err, bus_n.o_frame_err, bus_n.o_overrun, bus_n.o_break} !== 5'b0)
            $display("FAIL rstmid_flags got %b want 00000",
                     {bus_n.o_valid, bus_n.o_parity_err, bus_n.o_frame_err, bus_n.o_overrun, bus_n.o_break});
        else n_pass++;
        n_checks++;
        if (bus_n.o_data !== 8'h00) $display("FAIL rstmid_data got %h want 00", bus_n.o_data);
        else n_pass++;
        rst = 1'b0;
        bus_n.i_ready = 1'b1;
        idle(20);
        cap_n.delete();
        send_bits(0, f8n1(8'hC3, 1'b1), 10, 16, -1, 16'd0);
        idle(40);
        n_checks++;
        if (cap_n.size() !== 1 || cap_n[0] !== {2'b00, 8'hC3})
            $display("FAIL rstmid_next got n=%0d w=%h want n=1 w=0c3", cap_n.size(), cap_n[0]);
        else n_pass++;
    endtask

    task automatic test_divisor;
        cap_n.delete();
        div_n = 16'd16;
        send_bits(0, f8n1(8'hF0, 1'b1), 10, 16, -1, 16'd0);
        idle(40);
        div_n = 16'd9;
        idle(10);
        send_bits(0, f8n1(8'hF0, 1'b1), 10, 9, -1, 16'd0);
        idle(40);
        n_checks++;
        if (cap_n.size() !== 2 || cap_n[0] !== {2'b00, 8'hF0} || cap_n[1] !== {2'b00, 8'hF0})
            $display("FAIL div_switch got n=%0d w0=%h w1=%h want n=2 0f0 0f0", cap_n.size(), cap_n[0], cap_n[1]);
        else n_pass++;
        cap_n.delete();
        send_bits(0, f8n1(8'h96, 1'b1), 10, 9, 3, 16'd16);
        idle(40);
        n_checks++;
        if (cap_n.size() !== 1 || cap_n[0] !== {2'b00, 8'h96})
            $display("FAIL div_midframe got n=%0d w=%h want n=1 w=096", cap_n.size(), cap_n[0]);
        else n_pass++;
        div_n = 16'd16;
        idle(20);
    endtask

    initial begin
        bus_n.i_ready = 1'b1;
        bus_p.i_ready = 1'b1;
        test_reset();
        test_nominal();
        test_parity();
        test_frame_err();
        test_false_start();
        test_overrun();
        test_break();
        test_reset_mid();
        test_divisor();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised UART receiver, successor to the basic 8N1 receiver. It adds:
- a runtime baud divisor;
- configurable data width, parity and stop-bit count;
- 3-sample majority voting and false-start rejection;
- parity, framing, overrun and break detection;
- a valid/ready holding register.

It sits between the board RX pin and the command/FIFO logic in the FPGA designs.

## Interface
- DATA_BITS, 8: data bits per frame, 5..9
- PARITY, 0: 0 none, 1 odd, 2 even
- STOP_BITS, 1: stop bits checked, 1 or 2
- DIV_W, 16: width of the baud divisor input
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_rx  in  1  asynchronous serial line, idle high
- i_clks_per_bit  in  DIV_W  clocks per bit; legal values ≥ 8
- i_ready  in  1  consumer accepts the held word
- o_valid  out  1  holding register contains an unread word
- o_data  out  DATA_BITS  received word, LSB received first
- o_parity_err  out  1  parity mismatch on the held word; meaningful only while o_valid
- o_frame_err  out  1  a stop bit sampled 0 on the held word; meaningful only while o_valid
- o_overrun  out  1  one-cycle pulse: a completed frame was dropped
- o_break  out  1  one-cycle pulse: break condition detected

## Operation
- **Input synchronisation:** i_rx passes through the 2-stage `synchronizer`, reset value 1, with reset driven by ~rst. All logic below uses the synchronised line `rx_s`.
- **Bit timing:**
  - The divisor is latched into `div_q` on IDLE→START and held for the whole frame. Changing i_clks_per_bit mid-frame has no effect.
  - The sample counter runs 0..div_q-1 and wraps at div_q-1.
  - `mid = div_q>>1`.
  - The bit value is the majority of `rx_s` at counts mid-1, mid and mid+1. The decision is available at count mid+1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- **Transitions:**
  - IDLE → START when `rx_s`==0. The counter clears.
  - START: majority 1 → IDLE (false start, no outputs). Majority 0 → continue; enter DATA at the counter wrap.
  - DATA: shift the voted bit into the MSB, right shift. After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
  - PARITY: compute the expected bit as XOR(data) for even, ~XOR(data) for odd. Mismatch sets the parity error.
  - STOP: check STOP_BITS bits. Any voted 0 sets the frame error. The frame completes at the vote of the last stop bit, without waiting for the bit end, so the receiver resynchronises to the next falling edge. Go to IDLE.
  - Break: all data bits 0, parity bit 0 (if present), and the first stop bit 0 → pulse o_break. The frame is not delivered. Go to BREAK_WAIT.
  - BREAK_WAIT → IDLE when `rx_s`==1.
- **Holding register:**
  - On frame completion, load o_data and the error flags and set o_valid, if o_valid==0, or if o_valid&&i_ready in the same cycle.
  - Otherwise keep the old word and flags, drop the new frame, and pulse o_overrun.
  - o_valid clears on o_valid&&i_ready when no completion occurs in the same cycle.
  - o_valid is held indefinitely until i_ready.
- **Width rules:** sample counter and `div_q` are DIV_W bits wide; bit counter is $clog2(DATA_BITS+1) bits.

## Timing
- **Reset values:**
  - o_valid=0, o_data=0, o_parity_err=0, o_frame_err=0, o_overrun=0, o_break=0.
  - FSM=IDLE, counters=0.
- Reset mid-frame aborts immediately. No partial word appears, and the held word is discarded.
- Start-edge latency: 2 clk from i_rx falling to IDLE→START.
- o_valid rises 1 clk after the last stop-bit vote. For 8N1 with div D that is ≈ 2 + 9D + mid + 2 clk after the start edge.
- The receiver reaches IDLE ≈ D/2 before the nominal stop-bit end. Back-to-back frames are received with no lost bits.
- o_overrun and o_break are exactly 1 clk wide.

## Structure
- `uart_pkg` holds:
  - the parity enum `PARITY_NONE/ODD/EVEN`;
  - the FSM state enum;
  - the constant `UART_MIN_DIV=8`.
- One sub-module, `uart_bit_sampler`:
  - produces the sample counter, mid/wrap strobes and majority vote;
  - is reusable by a future TX-side loopback checker.
- Elaboration asserts DATA_BITS 5..9, PARITY 0..2 and STOP_BITS 1..2.

## Test plan
- **Nominal 8N1:** div=16, send 0x55 then 0xA3 back-to-back with i_ready=1 → two o_valid pulses, o_data 0x55 then 0xA3, no errors.
- **Parity, even:** PARITY=2, send 0xA5 with parity bit 1 (wrong) → o_valid with o_data=0xA5 and o_parity_err=1. Correct parity 0 → err=0.
- **Framing and false start:**
  - Stop bit driven 0 on 0x3C → o_frame_err=1.
  - Separate case: a 3-clk low glitch on idle → returns to IDLE, no o_valid.
- **Overrun:** i_ready=0, send 0x11 then 0x22 → o_valid stays, o_data=0x11, one o_overrun pulse. Then i_ready=1 → o_valid drops.
- **Break and reset:**
  - Hold i_rx low for 12 bit times → one o_break pulse, no o_valid. Release → next frame 0x7E received correctly.
  - Assert rst mid-data → all outputs 0, and the next full frame is received correctly.
- **Runtime divisor:** switch i_clks_per_bit 16→9 between frames, send 0xF0 at each rate → both received correctly. Change the divisor mid-frame → the current frame is unaffected.
